hs_sender: RTL and testbench

HS_SENDER -- requirements
Module: hs_sender

---
 rtl/hs_sender.sv | 114 +++++++++++
 tb/tb_hs_sender.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hs_sender.sv
// Four-phase request/acknowledge sender: latches a payload on send, raises req_out,
// waits for the synchronized acknowledge (or a timeout) and reports done or err.
module hs_sender #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send,
    input  logic [WIDTH-1:0] din,
    input  logic             ack_in,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL,
        FIN
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             ack_m_q, ack_m_d;
    logic             ack_s_q, ack_s_d;

    // ack_in is asynchronous to clk; only ack_s_q may be used by the FSM.
    assign ack_m_d = ack_in;
    assign ack_s_d = ack_m_q;

    // NOTE: every output of this block is given a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;

        unique case (state_q)
            IDLE: begin
                if (send) begin
                    data_d  = din;
                    req_d   = 1'b1;
                    cnt_d   = 8'd0;
                    abort_d = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s_q) begin
                    req_d   = 1'b0;
                    state_d = REL;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    abort_d = 1'b1;
                    state_d = REL;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            REL: begin
                // A late acknowledge after a timeout is drained here before returning.
                if (!ack_s_q) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= 8'd0;
            abort_q <= 1'b0;
            ack_m_q <= 1'b0;
            ack_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            ack_m_q <= ack_m_d;
            ack_s_q <= ack_s_d;
        end
    end

    assign req_out  = req_q;
    assign data_out = data_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN) && !abort_q;
    assign err      = (state_q == FIN) && abort_q;

endmodule

// File: tb/tb_hs_sender.sv
// Directed bench for hs_sender: one instance at the default timeout, one at TIMEOUT=4.
module tb_hs_sender;

    typedef struct {
        logic       send;
        logic [7:0] din;
        logic       ack;
        logic       exp_req;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;

    logic       send_a, ack_drv_a, loop_a, ack_a;
    logic [7:0] din_a, data_a;
    logic       req_a, busy_a, done_a, err_a;
    assign ack_a = loop_a ? req_a : ack_drv_a;

    logic       send_b, ack_b;
    logic [7:0] din_b, data_b;
    logic       req_b, busy_b, done_b, err_b;

    hs_sender #(.WIDTH(8), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .send(send_a), .din(din_a), .ack_in(ack_a),
        .req_out(req_a), .data_out(data_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    hs_sender #(.WIDTH(8), .TIMEOUT(4)) dut_t (
        .clk(clk), .reset(reset), .send(send_b), .din(din_b), .ack_in(ack_b),
        .req_out(req_b), .data_out(data_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dones, accepts;
        logic prev_busy, prev_req;

        // Basic transfer with ignored sends during REQ, REL and FIN.
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[2]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[5]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[9]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};

        reset = 1'b0;
        send_a = 1'b0; din_a = 8'h00; ack_drv_a = 1'b0; loop_a = 1'b0;
        send_b = 1'b0; din_b = 8'h00; ack_b = 1'b0;

        #12;
        check("reset req_a",  req_a,  1'b0);
        check("reset busy_a", busy_a, 1'b0);
        check("reset done_a", done_a, 1'b0);
        check("reset err_a",  err_a,  1'b0);
        check("reset data_a", data_a, 8'h00);
        check("reset req_b",  req_b,  1'b0);

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            send_a    = vecs[i].send;
            din_a     = vecs[i].din;
            ack_drv_a = vecs[i].ack;
            step();
            check($sformatf("vec%0d req",  i), req_a,  vecs[i].exp_req);
            check($sformatf("vec%0d busy", i), busy_a, vecs[i].exp_busy);
            check($sformatf("vec%0d done", i), done_a, vecs[i].exp_done);
            check($sformatf("vec%0d err",  i), err_a,  vecs[i].exp_err);
            check($sformatf("vec%0d data", i), data_a, vecs[i].exp_data);
        end

        // Timeout with ack held low: four cycles in REQ, then one err pulse.
        send_b = 1'b1; din_b = 8'h3C;
        step();
        check("to req@0", req_b, 1'b1);
        send_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("to req@%0d", k),  req_b,  (k < 4));
            check($sformatf("to err@%0d", k),  err_b,  (k == 5));
            check($sformatf("to done@%0d", k), done_b, 1'b0);
            check($sformatf("to data@%0d", k), data_b, 8'h3C);
        end
        check("to busy end", busy_b, 1'b0);

        // Ack arrives too late to beat the timeout: absorbed in REL, then err.
        send_b = 1'b1; din_b = 8'hC3;
        step();
        send_b = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            ack_b = (k >= 3 && k <= 5);
            step();
            check($sformatf("late req@%0d", k),  req_b,  (k < 4));
            check($sformatf("late busy@%0d", k), busy_b, (k < 9));
            check($sformatf("late err@%0d", k),  err_b,  (k == 8));
            check($sformatf("late done@%0d", k), done_b, 1'b0);
        end
        check("late data", data_b, 8'hC3);

        // Reset in the middle of REQ clears everything without a clock edge.
        send_a = 1'b1; din_a = 8'h77;
        step();
        send_a = 1'b0;
        step();
        check("mid req before", req_a, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("mid reset req",  req_a,  1'b0);
        check("mid reset busy", busy_a, 1'b0);
        check("mid reset data", data_a, 8'h00);
        check("mid reset done", done_a, 1'b0);
        check("mid reset err",  err_a,  1'b0);
        @(negedge clk);
        reset  = 1'b1;
        loop_a = 1'b1;
        send_a = 1'b1; din_a = 8'h5A;
        step();
        check("post reset accept", req_a, 1'b1);
        check("post reset data", data_a, 8'h5A);
        send_a = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("post done@%0d", k), done_a, (k == 6));
            check($sformatf("post err@%0d", k),  err_a,  1'b0);
        end
        check("post busy end", busy_a, 1'b0);

        // Back-to-back with send held high and ack looped back: one accept every 8 cycles.
        send_a = 1'b1; din_a = 8'h80;
        step();
        check("b2b first accept", req_a, 1'b1);
        dones = 0;
        accepts = 0;
        for (int k = 1; k <= 64; k++) begin
            din_a     = 8'(8'h80 + k);
            prev_busy = busy_a;
            prev_req  = req_a;
            step();
            check($sformatf("b2b rise@%0d", k), (req_a && !prev_req), (k % 8 == 0));
            if (req_a && !prev_req) begin
                accepts++;
                check($sformatf("b2b idle@%0d", k), prev_busy, 1'b0);
                check($sformatf("b2b data@%0d", k), data_a, din_a);
            end
            if (done_a) dones++;
            check($sformatf("b2b err@%0d", k), err_a, 1'b0);
        end
        check("b2b accepts", accepts, 8);
        check("b2b dones", dones, 8);
        send_a = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("b2b drained", busy_a, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
